adpcm_main_sdiv_46s_16s_32_seq: RTL and testbench

Iterative signed restoring divider for the ADPCM datapath. It is the inverse companion of the 16s x 32s -> 46 multiplier: it takes a 46-bit signed product-domain value and divides it by a 16-bit signed operand to recover a 32-bit signed quotient and a 16-bit remainder. It uses a start/ready/done handshake, computes one quotient bit per enabled clock, and has a global ce stall input.

---
 rtl/adpcm_div_pkg.sv | 19 +
 rtl/adpcm_div_step.sv | 23 ++
 rtl/adpcm_main_sdiv_46s_16s_32_seq.sv | 154 +++++++++++++++
 tb/tb_adpcm_main_sdiv_46s_16s_32_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_div_pkg.sv
// Shared types and constants for the ADPCM sequential signed divider.
// Widths, FSM states and saturation limits used by the divider and its step.
package adpcm_div_pkg;

   localparam int DIN0_W = 46;
   localparam int DIN1_W = 16;
   localparam int DOUT_W = 32;
   localparam int CNT_W  = $clog2(DIN0_W + 1);

   localparam logic [DOUT_W-1:0] QMAX = 32'h7FFF_FFFF;
   localparam logic [DOUT_W-1:0] QMIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_e;

endpackage

// File: rtl/adpcm_div_step.sv
// One restoring division iteration, purely combinational.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module adpcm_div_step
   import adpcm_div_pkg::*;
#(
   parameter int W = DIN1_W
) (
   input  logic [W:0]   i_pr,
   input  logic         i_bit,
   input  logic [W-1:0] i_dvs,
   output logic [W:0]   o_pr,
   output logic         o_q
);

   logic [W+1:0] w_cat;
   logic [W+1:0] w_dvs;

   assign w_cat = {i_pr, i_bit};
   assign w_dvs = {2'b00, i_dvs};
   assign o_q   = (w_cat >= w_dvs);
   assign o_pr  = o_q ? (W+1)'(w_cat - w_dvs) : (W+1)'(w_cat);

endmodule

// File: rtl/adpcm_main_sdiv_46s_16s_32_seq.sv
// Iterative signed restoring divider: 46s / 16s -> 32s quotient, 16s remainder.
// One quotient bit per enabled clock, saturating quotient, divide-by-zero flag.
module adpcm_main_sdiv_46s_16s_32_seq
   import adpcm_div_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = DIN0_W,
   parameter int din1_WIDTH = DIN1_W,
   parameter int dout_WIDTH = DOUT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  div_by_zero,
   output logic                  overflow
);

   localparam int D0 = din0_WIDTH;
   localparam int D1 = din1_WIDTH;
   localparam int DO = dout_WIDTH;
   localparam int CW = $clog2(D0 + 1);

   state_e        r_state;
   state_e        w_next;
   logic [CW-1:0] r_cnt;
   logic [D0-1:0] r_dvd;
   logic [D1-1:0] r_dvs;
   logic [D1:0]   r_pr;
   logic          r_sq;
   logic          r_sr;
   logic          r_dz;

   logic          w_accept;
   logic [D0-1:0] w_a0;
   logic [D1-1:0] w_a1;
   logic [D1:0]   w_pr;
   logic          w_qb;
   logic          w_pos_ovf;
   logic          w_neg_ovf;
   logic          w_ovf;
   logic [DO-1:0] w_qlo;
   logic [DO-1:0] w_qs;
   logic [D1-1:0] w_rmag;
   logic [D1-1:0] w_rs;
   logic [D1-1:0] w_dzr;

   assign ready    = (r_state == IDLE);
   assign w_accept = start & ready & ce;
   assign w_a0     = din0[D0-1] ? -din0 : din0;
   assign w_a1     = din1[D1-1] ? -din1 : din1;

   adpcm_div_step #(.W(D1)) u_step (
      .i_pr  (r_pr),
      .i_bit (r_dvd[D0-1]),
      .i_dvs (r_dvs),
      .o_pr  (w_pr),
      .o_q   (w_qb)
   );

   // Sign application and range checks on the finished magnitudes.
   assign w_pos_ovf = |r_dvd[D0-1:DO-1];
   assign w_neg_ovf = (|r_dvd[D0-1:DO]) | (r_dvd[DO-1] & (|r_dvd[DO-2:0]));
   assign w_ovf     = r_sq ? w_neg_ovf : w_pos_ovf;
   assign w_qlo     = r_dvd[DO-1:0];
   assign w_qs      = r_sq ? -w_qlo : w_qlo;
   assign w_rmag    = r_pr[D1-1:0];
   assign w_rs      = r_sr ? -w_rmag : w_rmag;
   assign w_dzr     = r_sr ? -r_dvd[D1-1:0] : r_dvd[D1-1:0];

   // State register, frozen while ce is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else if (ce)
         r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next = (din1 == '0) ? FIN : CALC;
         CALC: if (r_cnt == CW'(1)) w_next = FIN;
         FIN:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture and one restoring step per enabled CALC cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_dvd <= '0;
         r_dvs <= '0;
         r_pr  <= '0;
         r_sq  <= 1'b0;
         r_sr  <= 1'b0;
         r_dz  <= 1'b0;
      end else if (ce) begin
         if (r_state == IDLE && start) begin
            r_dvd <= w_a0;
            r_dvs <= w_a1;
            r_pr  <= '0;
            r_cnt <= CW'(D0);
            r_sq  <= din0[D0-1] ^ din1[D1-1];
            r_sr  <= din0[D0-1];
            r_dz  <= (din1 == '0);
         end else if (r_state == CALC) begin
            r_pr  <= w_pr;
            r_dvd <= {r_dvd[D0-2:0], w_qb};
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   // Result registers; done pulses for one enabled cycle after FIN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done        <= 1'b0;
         dout        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (ce) begin
         done <= (r_state == FIN);
         if (r_state == FIN) begin
            if (r_dz) begin
               dout        <= r_sr ? QMIN : QMAX;
               rem         <= w_dzr;
               div_by_zero <= 1'b1;
               overflow    <= 1'b0;
            end else if (w_ovf) begin
               dout        <= r_sq ? QMIN : QMAX;
               rem         <= w_rs;
               div_by_zero <= 1'b0;
               overflow    <= 1'b1;
            end else begin
               dout        <= w_qs;
               rem         <= w_rs;
               div_by_zero <= 1'b0;
               overflow    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_adpcm_main_sdiv_46s_16s_32_seq.sv
// Self-checking bench for the sequential signed divider.
// Random and directed operands are compared against a plain-arithmetic model.
module tb_adpcm_main_sdiv_46s_16s_32_seq;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        start;
   logic [45:0] din0;
   logic [15:0] din1;
   logic        ready;
   logic        done;
   logic [31:0] dout;
   logic [15:0] rem;
   logic        div_by_zero;
   logic        overflow;

   int n_chk = 0;
   int n_err = 0;

   adpcm_main_sdiv_46s_16s_32_seq dut (
      .clk         (clk),
      .reset       (reset),
      .ce          (ce),
      .start       (start),
      .din0        (din0),
      .din1        (din1),
      .ready       (ready),
      .done        (done),
      .dout        (dout),
      .rem         (rem),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: signed division truncating toward zero, saturating.
   task automatic model(input longint a, input longint b,
                        output logic [31:0] q, output logic [15:0] r,
                        output logic dz, output logic ov);
      longint qq;
      longint rr;
      if (b == 0) begin
         dz = 1'b1;
         ov = 1'b0;
         q  = (a >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
         r  = a[15:0];
      end else begin
         qq = a / b;
         rr = a % b;
         dz = 1'b0;
         r  = rr[15:0];
         if (qq > 64'sd2147483647) begin
            q = 32'h7FFF_FFFF; ov = 1'b1;
         end else if (qq < -64'sd2147483648) begin
            q = 32'h8000_0000; ov = 1'b1;
         end else begin
            q = qq[31:0]; ov = 1'b0;
         end
      end
   endtask

   task automatic run_op(input string tag, input longint a, input longint b,
                         input int ce_at, input int ce_len);
      logic [31:0] eq;
      logic [15:0] er;
      logic        edz;
      logic        eov;
      logic [31:0] held;
      int          n;
      int          lat;
      bit          bad_rdy;
      model(a, b, eq, er, edz, eov);
      lat = (b == 0) ? 1 : 47;
      if (ce_at >= 0) lat += ce_len;
      @(negedge clk);
      check({tag, ".rdy_in"}, 64'(ready), 64'd1);
      din0  = a[45:0];
      din1  = b[15:0];
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      n       = 0;
      bad_rdy = 1'b0;
      while (!done && n < 300) begin
         if (ready) bad_rdy = 1'b1;
         if (n == ce_at) ce = 1'b0;
         if (ce_at >= 0 && n == ce_at + ce_len) ce = 1'b1;
         @(negedge clk);
         n++;
      end
      ce = 1'b1;
      check({tag, ".lat"}, 64'(n), 64'(lat));
      check({tag, ".busy"}, 64'(bad_rdy), 64'd0);
      check({tag, ".dout"}, 64'(dout), 64'(eq));
      check({tag, ".rem"}, 64'(rem), 64'(er));
      check({tag, ".dz"}, 64'(div_by_zero), 64'(edz));
      check({tag, ".ov"}, 64'(overflow), 64'(eov));
      check({tag, ".rdy"}, 64'(ready), 64'd1);
      held = dout;
      @(negedge clk);
      check({tag, ".pulse"}, 64'(done), 64'd0);
      check({tag, ".hold"}, 64'(dout), 64'(held));
   endtask

   function automatic longint rnd_a();
      longint ra;
      ra = longint'({$urandom, $urandom});
      return ra >>> (18 + $urandom_range(0, 40));
   endfunction

   function automatic longint rnd_b();
      longint rb;
      rb = longint'(shortint'($urandom));
      return rb >>> $urandom_range(0, 14);
   endfunction

   task automatic reset_mid();
      int  n;
      bit  saw;
      @(negedge clk);
      din0  = 46'd123456789;
      din1  = 16'd321;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst.rdy", 64'(ready), 64'd1);
      check("rst.done", 64'(done), 64'd0);
      check("rst.dout", 64'(dout), 64'd0);
      check("rst.rem", 64'(rem), 64'd0);
      check("rst.flags", 64'({div_by_zero, overflow}), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      saw   = 1'b0;
      for (n = 0; n < 80; n++) begin
         @(negedge clk);
         if (done) saw = 1'b1;
      end
      check("rst.nodone", 64'(saw), 64'd0);
   endtask

   task automatic back_to_back();
      longint      av[4];
      longint      bv[4];
      logic [31:0] eq;
      logic [15:0] er;
      logic        edz;
      logic        eov;
      int          n;
      for (int i = 0; i < 4; i++) begin
         av[i] = rnd_a() >>> 12;
         bv[i] = rnd_b();
         if (bv[i] == 0) bv[i] = 3;
      end
      @(negedge clk);
      din0  = av[0][45:0];
      din1  = bv[0][15:0];
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!done && n < 300);
         model(av[i], bv[i], eq, er, edz, eov);
         check("b2b.gap", 64'(n), 64'd48);
         check("b2b.dout", 64'(dout), 64'(eq));
         check("b2b.rem", 64'(rem), 64'(er));
         check("b2b.ov", 64'(overflow), 64'(eov));
         if (i < 3) begin
            din0 = av[i+1][45:0];
            din1 = bv[i+1][15:0];
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      longint a;
      longint b;
      reset = 1'b1;
      ce    = 1'b1;
      start = 1'b0;
      din0  = '0;
      din1  = '0;
      #2 reset = 1'b0;
      #4;
      check("init.rdy", 64'(ready), 64'd1);
      check("init.done", 64'(done), 64'd0);
      check("init.dout", 64'(dout), 64'd0);
      check("init.rem", 64'(rem), 64'd0);
      check("init.flags", 64'({div_by_zero, overflow}), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op("pp", 1000, 7, -1, 0);
      run_op("np", -1000, 7, -1, 0);
      run_op("pn", 1000, -7, -1, 0);
      run_op("nn", -1000, -7, -1, 0);
      run_op("min45", -(64'sd1 <<< 45), 1, -1, 0);
      run_op("min31", -(64'sd1 <<< 31), 1, -1, 0);
      run_op("big40", 64'sd1 <<< 40, 1, -1, 0);
      run_op("dzneg", -5, 0, -1, 0);
      run_op("dzpos", 77, 0, -1, 0);
      run_op("dvmin", -(64'sd1 <<< 45), -32768, -1, 0);
      run_op("remmx", 64'sd1 <<< 44, -32768 + 1, -1, 0);
      run_op("stall", 1000, 7, 20, 10);
      reset_mid();

      for (int i = 0; i < 30; i++) begin
         a = rnd_a();
         b = rnd_b();
         run_op("rnd", a, b, -1, 0);
      end

      back_to_back();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
